sram_responder: RTL and testbench

//  Memory-side responder for the core's instruction/data fetch path: accepts one

---
 rtl/sram_responder_if.sv | 29 ++
 rtl/sram_responder.sv | 111 +++++++++++
 tb/tb_sram_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// sram_if: request/response channel between a fetch/LSU initiator and the
// memory-side responder.
//   Request  (initiator -> responder): req_valid, req_wen, req_addr,
//            req_wdata, req_wmask; responder answers with req_ready.
//   Response (responder -> initiator): resp_valid, resp_rdata, resp_err;
//            initiator answers with resp_ready.
// Modports: master = initiator side, slave = responder side.
interface sram_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder with a fixed access latency.
// Accepts one read or write request at a time, services it from an internal
// word array and returns a response once LATENCY cycles have elapsed.
// Ports:
//   i_clock  clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      sram_if.slave: request channel (valid/ready, wen, addr, wdata,
//            wmask) and response channel (valid/ready, rdata, err)
// Parameters:
//   ADDR_BASE    byte address mapped to word 0
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      cycles from request accept to response valid (>= 1)
module sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic   i_clock,
  input  logic   i_reset,
  sram_if.slave  bus
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH_WORDS);
  // Counter only ever holds values 1..LATENCY-1.
  localparam int CW     = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rdata_p0;
  logic              err_p0;

  logic [31:0]       offset;
  logic [31:0]       word_idx;
  logic              in_range;
  logic              accept;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [3:0]        mask
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  // Unsigned 32-bit subtract: addresses below the base wrap to a huge index
  // and therefore fall out of range without a separate lower-bound compare.
  assign offset   = bus.req_addr - ADDR_BASE;
  assign word_idx = offset >> 2;
  assign in_range = word_idx < 32'(DEPTH_WORDS);
  assign accept   = (state == ST_IDLE) && bus.req_valid && !i_reset;

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = rdata_p0;
  assign bus.resp_err   = err_p0;

  // ---- stage p0: accept edge captures the response, then latency countdown
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rdata_p0 <= '0;
      err_p0   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rdata_p0 <= (!bus.req_wen && in_range) ? mem[word_idx[AW-1:0]] : '0;
            err_p0   <= !in_range;
            if (LATENCY == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == CW'(1)) state <= ST_RESP;
          else               cnt   <= cnt - CW'(1);
        end
        ST_RESP: begin
          if (bus.resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writes commit at the accept edge, so a reset arriving later in the
  // transaction cannot undo them.
  always_ff @(posedge i_clock) begin
    if (accept && bus.req_wen && in_range) begin
      mem[word_idx[AW-1:0]] <= merge_bytes(mem[word_idx[AW-1:0]], bus.req_wdata,
                                           bus.req_wmask);
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;
  localparam int          LAT   = 3;

  logic clk = 1'b0;
  logic rst;
  sram_if bus();

  sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory: plain word array indexed by (addr - BASE) / 4.
  logic [31:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint la, lb;
    la = {32'h0, a};
    lb = {32'h0, BASE};
    return (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  task automatic model_apply(input logic wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wmask,
                             output logic [31:0] er, output logic ee);
    int idx;
    if (!addr_ok(addr)) begin
      er = 32'h0;
      ee = 1'b1;
    end else begin
      idx = int'(({32'h0, addr} - {32'h0, BASE}) / 4);
      ee = 1'b0;
      if (wen) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        er = 32'h0;
      end else begin
        er = model[idx];
      end
    end
  endtask

  // Full transaction; entered and left at #1 after a rising edge.
  task automatic txn(input string tag, input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask);
    logic [31:0] er;
    logic        ee;
    int          n;
    model_apply(wen, addr, wdata, wmask, er, ee);
    bus.req_wen    = wen;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_wmask  = wmask;
    bus.req_valid  = 1'b1;
    bus.resp_ready = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("%s_accept_timeout", tag), 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check($sformatf("%s_latency", tag), 32'(n + 1), 32'(LAT));
    check($sformatf("%s_rdata", tag), bus.resp_rdata, er);
    check($sformatf("%s_err", tag), 32'(bus.resp_err), 32'(ee));
    @(posedge clk); #1;
    check($sformatf("%s_idle_after", tag), {30'h0, bus.resp_valid, bus.req_ready}, 32'h1);
  endtask

  // Presents a request and returns right after the accept edge (+#1).
  task automatic accept_only(input logic wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wmask);
    int n;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("accept_only_timeout", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er, ee32, cap_rdata;
    logic        ee, cap_err;
    logic [31:0] addrs [4];
    logic [31:0] exps  [4];
    logic [31:0] pool  [8];
    logic [31:0] a;
    int          n, prev;

    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_wmask  = 4'h0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_rdata", bus.resp_rdata, 32'h0);
    check("reset_err", 32'(bus.resp_err), 32'd0);

    // Basic write then read.
    txn("t1_wr", 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    txn("t1_rd", 1'b0, BASE + 32'h10, 32'h0, 4'h0);

    // Byte-masked overwrite.
    txn("t2_wr_full", 1'b1, BASE + 32'h20, 32'h11223344, 4'hF);
    txn("t2_wr_mask", 1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101);
    txn("t2_rd", 1'b0, BASE + 32'h20, 32'h0, 4'h0);
    check("t2_model", model[8], 32'h11BB33DD);
    txn("t2_wr_nomask", 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'h0);
    txn("t2_rd_nomask", 1'b0, BASE + 32'h20, 32'h0, 4'h0);

    // Out-of-range on both sides; an out-of-range write must not alias.
    txn("t3_wr_w0", 1'b1, BASE, 32'h0BADF00D, 4'hF);
    txn("t3_wr_last", 1'b1, BASE + 4 * (DEPTH - 1), 32'hC0FFEE11, 4'hF);
    txn("t3_rd_below", 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    txn("t3_rd_above", 1'b0, BASE + 4 * DEPTH, 32'h0, 4'h0);
    txn("t3_wr_above", 1'b1, BASE + 4 * DEPTH, 32'h12345678, 4'hF);
    txn("t3_wr_below", 1'b1, BASE - 4, 32'h87654321, 4'hF);
    txn("t3_rd_w0", 1'b0, BASE, 32'h0, 4'h0);
    txn("t3_rd_last", 1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0);

    // Response back-pressure with a competing request that must be ignored.
    model_apply(1'b0, BASE + 32'h10, 32'h0, 4'h0, er, ee);
    bus.resp_ready = 1'b1;
    accept_only(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    check("t4_valid_timeout", 32'(n < 50), 32'd1);
    bus.resp_ready = 1'b0;
    cap_rdata = bus.resp_rdata;
    cap_err   = bus.resp_err;
    check("t4_rdata", cap_rdata, er);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = BASE + 32'h20;
    bus.req_wdata = 32'h55555555;
    bus.req_wmask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("t4_hold%0d_valid", i), 32'(bus.resp_valid), 32'd1);
      check($sformatf("t4_hold%0d_ready", i), 32'(bus.req_ready), 32'd0);
      check($sformatf("t4_hold%0d_rdata", i), bus.resp_rdata, cap_rdata);
      check($sformatf("t4_hold%0d_err", i), 32'(bus.resp_err), 32'(cap_err));
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release", {30'h0, bus.resp_valid, bus.req_ready}, 32'h1);
    txn("t4_ignored_write", 1'b0, BASE + 32'h20, 32'h0, 4'h0);

    // Back-to-back reads with request valid and response ready held high.
    addrs[0] = BASE + 32'h10;
    addrs[1] = BASE + 32'h20;
    addrs[2] = BASE;
    addrs[3] = BASE + 4 * (DEPTH - 1);
    for (int k = 0; k < 4; k++) begin
      model_apply(1'b0, addrs[k], 32'h0, 4'h0, er, ee);
      exps[k] = er;
    end
    bus.req_wen    = 1'b0;
    bus.req_addr   = addrs[0];
    bus.req_valid  = 1'b1;
    bus.resp_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) bus.req_addr = addrs[k + 1];
      n = 0;
      while (bus.resp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      check($sformatf("t5_rdata%0d", k), bus.resp_rdata, exps[k]);
      if (k > 0) check($sformatf("t5_period%0d", k), 32'(cyc - prev), 32'(LAT + 1));
      prev = cyc;
      @(posedge clk); #1;
      if (k == 3) bus.req_valid = 1'b0;
    end

    // Reset in WAIT after a read: response dropped, response regs cleared.
    accept_only(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6a_valid", 32'(bus.resp_valid), 32'd0);
    check("t6a_ready", 32'(bus.req_ready), 32'd1);
    check("t6a_rdata", bus.resp_rdata, 32'h0);
    // Reset in WAIT after a write: write stays committed, no response.
    model_apply(1'b1, BASE + 32'h30, 32'hCAFEF00D, 4'hF, er, ee);
    accept_only(1'b1, BASE + 32'h30, 32'hCAFEF00D, 4'hF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6b_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6b_novalid%0d", i), 32'(bus.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    txn("t6_rd", 1'b0, BASE + 32'h30, 32'h0, 4'h0);

    // Randomised traffic over a small pool of initialised words.
    for (int p = 0; p < 8; p++) begin
      pool[p] = BASE + 4 * $urandom_range(0, DEPTH - 1);
      txn($sformatf("rnd_init%0d", p), 1'b1, pool[p], $urandom, 4'hF);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 4 * $urandom_range(1, 1000);
        else                          a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000);
      end else begin
        a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      end
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
          4'($urandom_range(0, 15)));
    end

    ee32 = 32'h0;
    if (ee32 == 32'h0) begin end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
